// File: rtl/key_event_ctrl_pkg.sv
// Shared types and helpers for the key event controller: FSM states,
// the default lockout length and the round-robin grant picker.
package key_ctrl_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        LOCKOUT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_DUR = 5_000_000 - 1;
    localparam int unsigned MAX_KEYS    = 32;
    localparam int unsigned MAX_KW      = 5;

    // First set bit at or above ptr, wrapping at nkeys; 0 when nothing is set.
    function automatic int unsigned rr_pick(
        input logic [MAX_KEYS-1:0] keys,
        input int unsigned         ptr,
        input int unsigned         nkeys
    );
        int unsigned idx;
        int unsigned grant;
        logic        found;
        grant = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_KEYS; i++) begin
            if (i < nkeys) begin
                idx = ptr + i;
                if (idx >= nkeys) idx = idx - nkeys;
                if (!found && keys[idx[MAX_KW-1:0]]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/key_event_ctrl_if.sv
// Event handshake between the key controller and the processor input port.
interface key_event_ctrl_if #(
    parameter int unsigned NKEYS = 4
);
    localparam int unsigned KW = $clog2(NKEYS);

    logic          EvValid;
    logic [KW-1:0] EvKey;
    logic          EvReady;

    modport master (output EvValid, output EvKey, input EvReady);
    modport slave  (input EvValid, input EvKey, output EvReady);
endinterface

// File: rtl/key_event_fifo.sv
// Small synchronous FIFO of accepted key indices; head reads as 0 when empty.
module key_event_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNTW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full queue still lands when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Shared-timer debounce: one lockout countdown serves all keys, picked
// round-robin; accepted presses are queued as key indices for the processor.
module key_event_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int unsigned NKEYS      = 4,
    parameter int unsigned DUR        = DEFAULT_DUR,
    parameter int unsigned CW         = 33,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [NKEYS-1:0] Keys,
    key_event_ctrl_if.master ev,
    output logic             Strobe,
    output logic             Busy,
    output logic             Overflow
);
    localparam int unsigned KW = $clog2(NKEYS);

    state_t        state;
    logic [CW-1:0] countdown;
    logic [KW-1:0] rr_ptr;
    logic [KW-1:0] grant;
    logic [KW-1:0] next_ptr;
    logic          accept;
    logic          fifo_full;
    logic          fifo_empty;

    assign grant    = KW'(rr_pick(MAX_KEYS'(Keys), 32'(rr_ptr), NKEYS));
    assign next_ptr = (grant == KW'(NKEYS - 1)) ? '0 : grant + KW'(1);
    assign accept   = (state == IDLE) && (|Keys);

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KW)
    ) u_fifo (
        .Clock  (Clock),
        .Resetn (Resetn),
        .push   (accept),
        .pop    (ev.EvReady),
        .din    (grant),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (ev.EvKey)
    );

    assign ev.EvValid = !fifo_empty;

    // Lockout FSM; Strobe/Busy are registered alongside the state.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state     <= IDLE;
            countdown <= '0;
            rr_ptr    <= '0;
            Overflow  <= 1'b0;
            Strobe    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        countdown <= CW'(DUR);
                        rr_ptr    <= next_ptr;
                        state     <= LOCKOUT;
                        Strobe    <= 1'b0;
                        Busy      <= 1'b1;
                        // Full without a concurrent pop means the press is lost.
                        if (fifo_full && !ev.EvReady) Overflow <= 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (countdown == '0) begin
                        state  <= IDLE;
                        Strobe <= 1'b1;
                        Busy   <= 1'b0;
                    end else begin
                        countdown <= countdown - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    Strobe <= 1'b1;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomised and directed bench for key_event_ctrl against a timing/queue model.
module tb_key_event_ctrl;
    localparam int NK    = 4;
    localparam int DUR   = 2;
    localparam int DEPTH = 4;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [3:0] Keys;
    logic       Strobe;
    logic       Busy;
    logic       Overflow;

    key_event_ctrl_if #(.NKEYS(NK)) ev ();

    key_event_ctrl #(
        .NKEYS      (NK),
        .DUR        (DUR),
        .CW         (33),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Keys     (Keys),
        .ev       (ev),
        .Strobe   (Strobe),
        .Busy     (Busy),
        .Overflow (Overflow)
    );

    always #5 Clock = ~Clock;

    // Model: queue of key indices, edge index before which no accept may occur.
    int q[$];
    int lock_until = -1;
    int last_edge  = -1;
    int ptr        = 0;
    bit ovf        = 1'b0;
    int cyc        = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    logic [5:0] got;

    function automatic int pick(input logic [3:0] k, input int p);
        for (int i = 0; i < NK; i++) begin
            if (k[(p + i) % NK]) return (p + i) % NK;
        end
        return 0;
    endfunction

    function automatic logic [5:0] expv();
        bit         busy;
        bit         valid;
        logic [1:0] key;
        busy  = (last_edge < lock_until);
        valid = (q.size() > 0);
        key   = valid ? 2'(q[0]) : 2'd0;
        return {valid, key, !busy, busy, ovf};
    endfunction

    task automatic step(input logic [3:0] k, input logic r, input logic rn);
        int g;
        Keys       = k;
        ev.EvReady = r;
        Resetn     = rn;
        if (!rn) begin
            q.delete();
            lock_until = cyc;
            ptr        = 0;
            ovf        = 1'b0;
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (cyc > lock_until && k != 4'd0) begin
                g = pick(k, ptr);
                if (q.size() < DEPTH) q.push_back(g);
                else ovf = 1'b1;
                ptr        = (g + 1) % NK;
                lock_until = cyc + DUR + 1;
            end
        end
        last_edge = cyc;
        cyc++;
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        step(4'd0, 1'b0, 1'b0);
        step(4'd0, 1'b0, 1'b0);
        got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
        n_checks++;
        if (got !== 6'b000100) begin
            n_fail++;
            $display("FAIL reset_state got=%b want=%b", got, 6'b000100);
        end
    endtask

    task automatic test_hold_repeat();
        int evs = 0;
        int busy_cnt = 0;
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(4'b0001, 1'b1, 1'b1);
            got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL hold_step cyc=%0d got=%b want=%b", cyc, got, expv());
            end
            if (ev.EvValid) evs++;
            if (Busy) busy_cnt++;
        end
        n_checks++;
        if (evs !== 3 || busy_cnt !== 9) begin
            n_fail++;
            $display("FAIL hold_counts events=%0d busy=%0d want 3 and 9", evs, busy_cnt);
        end
    endtask

    task automatic test_round_robin();
        int seen[$];
        int want[4] = '{1, 3, 1, 3};
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(4'b1010, 1'b1, 1'b1);
            got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL rr_step cyc=%0d got=%b want=%b", cyc, got, expv());
            end
            if (ev.EvValid) seen.push_back(int'(ev.EvKey));
        end
        n_checks++;
        if (seen.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count got=%0d want=4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (seen[i] !== want[i]) begin
                    n_fail++;
                    $display("FAIL rr_seq idx=%0d got=%0d want=%0d", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int drained[$];
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 1'b0, 1'b1);
            got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL ovf_step cyc=%0d got=%b want=%b", cyc, got, expv());
            end
        end
        n_checks++;
        if (Overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag got=%b want=1", Overflow);
        end
        for (int i = 0; i < 6; i++) begin
            if (ev.EvValid) drained.push_back(int'(ev.EvKey));
            step(4'd0, 1'b1, 1'b1);
        end
        n_checks++;
        if (drained.size() != 4 || drained[0] != 2 || drained[3] != 2 || Overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain size=%0d ovf=%b want 4 entries of 2, ovf 1", drained.size(), Overflow);
        end
    endtask

    task automatic test_full_push_pop();
        int drained[$];
        bit idle = 1'b0;
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) step(4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 10 && !idle; i++) begin
            step(4'd0, 1'b0, 1'b1);
            idle = Strobe;
        end
        n_checks++;
        if (!idle) begin
            n_fail++;
            $display("FAIL fpp_idle_timeout strobe=%b want=1", Strobe);
        end
        step(4'b1000, 1'b1, 1'b1);
        got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
        n_checks++;
        if (got !== expv() || Overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fpp_step got=%b want=%b", got, expv());
        end
        for (int i = 0; i < 6; i++) begin
            if (ev.EvValid) drained.push_back(int'(ev.EvKey));
            step(4'd0, 1'b1, 1'b1);
        end
        n_checks++;
        if (drained.size() != 4 || drained[2] != 2 || drained[3] != 3) begin
            n_fail++;
            $display("FAIL fpp_drain size=%0d want 4 entries ending 2,3", drained.size());
        end
    endtask

    task automatic test_reset_mid();
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(4'b0001, 1'b0, 1'b1);
        step(4'd0, 1'b0, 1'b0);
        got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
        n_checks++;
        if (got !== 6'b000100) begin
            n_fail++;
            $display("FAIL midreset_clear got=%b want=%b", got, 6'b000100);
        end
        step(4'b0010, 1'b0, 1'b1);
        got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
        n_checks++;
        if (got !== 6'b101010) begin
            n_fail++;
            $display("FAIL midreset_accept got=%b want=%b", got, 6'b101010);
        end
    endtask

    task automatic test_pulse_in_lockout();
        step(4'd0, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(4'd0, 1'b0, 1'b1);
            got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL pulse_step cyc=%0d got=%b want=%b", cyc, got, expv());
            end
        end
        step(4'd0, 1'b1, 1'b1);
        n_checks++;
        if (ev.EvValid !== 1'b0) begin
            n_fail++;
            $display("FAIL pulse_single_event valid=%b want=0", ev.EvValid);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        logic       r;
        logic       rn;
        step(4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            k  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            r  = 1'($urandom_range(0, 2) == 0);
            rn = 1'($urandom_range(0, 63) != 0);
            step(k, r, rn);
            got = {ev.EvValid, ev.EvKey, Strobe, Busy, Overflow};
            n_checks++;
            if (got !== expv()) begin
                n_fail++;
                $display("FAIL random_step cyc=%0d got=%b want=%b", cyc, got, expv());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hold_repeat();
        test_round_robin();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        test_pulse_in_lockout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
